mega_ram_reader: RTL and testbench
==================================

MEGA_RAM_READER -- requirements
Module: mega_ram_reader

Interface
REQ-001 SHALL have parameter ADDR_BUS_WIDTH, default 12, RAM address width.
REQ-002 SHALL have parameter DATA_BUS_WIDTH, default 8, RAM data width.
REQ-003 SHALL have parameter LEN_WIDTH, default 12, width of transfer length.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of the current transfer.
REQ-008 base_addr  in  ADDR_BUS_WIDTH  first RAM address, captured on accepted start.
REQ-009 length  in  LEN_WIDTH  byte count, captured on accepted start.
REQ-010 ram_req  out  1  requests the RAM port.
REQ-011 ram_gnt  in  1  RAM port granted this cycle.
REQ-012 ram_a  out  ADDR_BUS_WIDTH  RAM read address.
REQ-013 ram_d  in  DATA_BUS_WIDTH  RAM read data, valid one cycle after address issue.
REQ-014 out_data  out  DATA_BUS_WIDTH  streamed byte.
REQ-015 out_valid  out  1  out_data valid.
REQ-016 out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-017 busy  out  1  high from accepted start until final byte accepted, or abort.
REQ-018 done  out  1  one-cycle pulse after final byte accepted.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start with length!=0; RUN->DRAIN when all length addresses issued; DRAIN->IDLE when final byte accepted.
REQ-020 start with length==0 SHALL stay in IDLE, issue no reads, pulse done the next cycle.
REQ-021 An address issue SHALL occur in a cycle with ram_req && ram_gnt; ram_req asserts only in RUN when buffer credit exists.
REQ-022 Credit SHALL be (in-flight reads + buffered bytes) < 2; the buffer holds 2 entries.
REQ-023 Data from ram_d SHALL be captured exactly one cycle after issue, regardless of ram_gnt in that cycle.
REQ-024 ram_a SHALL start at base_addr and increment by 1 per issue, wrapping modulo 2**ADDR_BUS_WIDTH.
REQ-025 Bytes SHALL leave in address order, no loss or duplication under any out_ready pattern.
REQ-026 out_data SHALL hold stable while out_valid && !out_ready.
REQ-027 Full throughput SHALL be one byte per cycle when ram_gnt and out_ready stay high; first byte out_valid two cycles after start.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort SHALL, next cycle, return to IDLE, flush buffer and in-flight read, deassert out_valid/ram_req/busy, no done pulse.
REQ-030 abort and start in the same cycle: abort wins, start ignored.

Reset
REQ-031 While rst low: state IDLE, ram_req=0, ram_a=0, out_valid=0, out_data=0, busy=0, done=0, counters and buffer cleared.
REQ-032 Reset mid-transfer SHALL discard all progress; no done pulse follows.

Configuration
REQ-033 Macro MEGA_RAM_READER_LOOP_EN SHALL add input loop (1 bit).
REQ-034 With MEGA_RAM_READER_LOOP_EN: on final byte accepted with loop high, done pulses and transfer restarts at captured base_addr/length in RUN without visiting IDLE; busy stays high.
REQ-035 Without it: no loop port; every transfer ends in IDLE.

Structure
REQ-036 Shared package mega_ram_pkg SHALL hold the FSM state enum and credit depth constant (2).
REQ-037 The 2-entry buffer SHALL be sub-module mega_ram_reader_skid (valid/ready in and out, synchronous flush).

Verification
REQ-038 base_addr=0x010, length=4, RAM[0x10..0x13]=A0..A3, gnt/ready=1 -> A0..A3 on cycles 2..5 after start, done cycle 6.
REQ-039 base_addr=0xFFE, length=4 -> addresses 0xFFE,0xFFF,0x000,0x001 in order.
REQ-040 length=8, out_ready toggling 1010..., ram_gnt low every third cycle -> 8 bytes in order, never >2 outstanding, out_data stable while stalled.
REQ-041 length=0 -> no ram_req, done pulses once, busy never high.
REQ-042 abort after 3rd byte of length=10 -> next cycle out_valid=0, busy=0, no done; new start length=2 delivers correct 2 bytes.
REQ-043 rst low mid-transfer -> outputs at reset values immediately; with MEGA_RAM_READER_LOOP_EN, loop=1, length=2 -> bytes B0,B1,B0,B1..., done each pass.

Source files
------------

// File: rtl/mega_ram_pkg.sv
// Shared definitions for the mega_ram_reader block: FSM state encoding,
// the read-buffer depth and the credit test used to throttle RAM requests.
package mega_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Number of bytes that may be in flight or buffered at any time.
    localparam int unsigned CREDIT_DEPTH = 32'd2;

    // A new read may be issued while the occupancy (in-flight reads plus
    // buffered bytes, net of a byte leaving this cycle) is below the depth.
    function automatic logic has_credit(input logic [2:0] occupancy);
        return ({29'd0, occupancy} < CREDIT_DEPTH);
    endfunction

endpackage

// File: rtl/mega_ram_reader_skid.sv
// Two-entry read buffer between the RAM read port and the byte stream.
// Valid/ready on both sides, synchronous flush that drops all contents.
// The head entry is held in a register, so out_data cannot move while stalled.
module mega_ram_reader_skid
    import mega_ram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [CREDIT_DEPTH];
    logic              wr_ptr_q;
    logic              wr_ptr_d;
    logic              rd_ptr_q;
    logic              rd_ptr_d;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              push_s;
    logic              pop_s;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign push_s      = in_valid_i && in_ready_o;
    assign pop_s       = out_valid_o && out_ready_i;

    // Next pointer/count values; flush empties the buffer and wins over traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            wr_ptr_d = wr_ptr_q ^ push_s;
            rd_ptr_d = rd_ptr_q ^ pop_s;
            count_d  = count_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Pointer/count registers and storage writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < int'(CREDIT_DEPTH); i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s && !flush_i) begin
                mem_q[wr_ptr_q] <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/mega_ram_reader.sv
// mega_ram_reader: streams `length` bytes from a synchronous-read RAM,
// starting at `base_addr`, out through a valid/ready byte interface.
// Reads are throttled so that in-flight reads plus buffered bytes never
// exceed the two-entry buffer, which still allows one byte per cycle.
// Optional feature: define MEGA_RAM_READER_LOOP_EN to add the `loop` input,
// which restarts the same transfer after each completed pass.
module mega_ram_reader
    import mega_ram_pkg::*;
#(
    parameter int ADDR_BUS_WIDTH = 12,
    parameter int DATA_BUS_WIDTH = 8,
    parameter int LEN_WIDTH      = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
`ifdef MEGA_RAM_READER_LOOP_EN
    input  logic                      loop,
`endif
    input  logic [ADDR_BUS_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]      length,
    output logic                      ram_req,
    input  logic                      ram_gnt,
    output logic [ADDR_BUS_WIDTH-1:0] ram_a,
    input  logic [DATA_BUS_WIDTH-1:0] ram_d,
    output logic [DATA_BUS_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    localparam logic [LEN_WIDTH-1:0]      LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]      LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BUS_WIDTH-1:0] ADDR_ONE  = {{(ADDR_BUS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BUS_WIDTH-1:0] ADDR_ZERO = {ADDR_BUS_WIDTH{1'b0}};

    state_e                      state_q, state_d;
    logic [ADDR_BUS_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]        issue_left_q, issue_left_d;
    logic [LEN_WIDTH-1:0]        byte_left_q, byte_left_d;
    logic                        inflight_q, inflight_d;
    logic                        done_q, done_d;
`ifdef MEGA_RAM_READER_LOOP_EN
    logic [ADDR_BUS_WIDTH-1:0]   base_q, base_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
`endif

    logic                        skid_in_ready_s;
    logic [1:0]                  skid_count_s;
    logic                        skid_flush_s;
    logic                        pop_s;
    logic                        issue_s;
    logic                        ram_req_s;
    logic [2:0]                  occ_s;

    // Occupancy seen by the credit check: a byte leaving this cycle frees
    // its slot in time for the read issued this cycle.
    assign occ_s     = {1'b0, skid_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign ram_req_s = (state_q == ST_RUN) && has_credit(occ_s) && skid_in_ready_s;
    assign issue_s   = ram_req_s && ram_gnt;
    assign pop_s     = out_valid && out_ready;

    assign ram_req   = ram_req_s;
    assign ram_a     = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    mega_ram_reader_skid #(
        .DATA_W(DATA_BUS_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (skid_flush_s),
        .in_valid_i (inflight_q),
        .in_ready_o (skid_in_ready_s),
        .in_data_i  (ram_d),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .count_o    (skid_count_s)
    );

    // Next-state logic: transfer sequencing, address/length bookkeeping, done pulse.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        byte_left_d  = byte_left_q;
        inflight_d   = issue_s;
        done_d       = 1'b0;
        skid_flush_s = 1'b0;
`ifdef MEGA_RAM_READER_LOOP_EN
        base_d       = base_q;
        len_d        = len_q;
`endif
        if (abort) begin
            // Cancel drops the read in flight and everything buffered.
            state_d      = ST_IDLE;
            inflight_d   = 1'b0;
            skid_flush_s = 1'b1;
            issue_left_d = LEN_ZERO;
            byte_left_d  = LEN_ZERO;
        end else begin
            if (pop_s) begin
                byte_left_d = byte_left_q - LEN_ONE;
            end else begin
                byte_left_d = byte_left_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (length == LEN_ZERO) begin
                            done_d = 1'b1;
                        end else begin
                            state_d      = ST_RUN;
                            addr_d       = base_addr;
                            issue_left_d = length;
                            byte_left_d  = length;
`ifdef MEGA_RAM_READER_LOOP_EN
                            base_d       = base_addr;
                            len_d        = length;
`endif
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        addr_d       = addr_q + ADDR_ONE;
                        issue_left_d = issue_left_q - LEN_ONE;
                        if (issue_left_q == LEN_ONE) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (pop_s && (byte_left_q == LEN_ONE)) begin
                        done_d = 1'b1;
`ifdef MEGA_RAM_READER_LOOP_EN
                        if (loop) begin
                            state_d      = ST_RUN;
                            addr_d       = base_q;
                            issue_left_d = len_q;
                            byte_left_d  = len_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= ADDR_ZERO;
            issue_left_q <= LEN_ZERO;
            byte_left_q  <= LEN_ZERO;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
`ifdef MEGA_RAM_READER_LOOP_EN
            base_q       <= ADDR_ZERO;
            len_q        <= LEN_ZERO;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            byte_left_q  <= byte_left_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
`ifdef MEGA_RAM_READER_LOOP_EN
            base_q       <= base_d;
            len_q        <= len_d;
`endif
        end
    end

endmodule

// File: tb/tb_mega_ram_reader.sv
// Self-checking bench for mega_ram_reader. A synchronous RAM model backs the
// read port; expected bytes are computed directly as mem[(base+i) mod 4096].
module tb_mega_ram_reader;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
`ifdef MEGA_RAM_READER_LOOP_EN
    logic          loop;
`endif
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          ram_req;
    logic          ram_gnt;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [4096];

    int n_tests = 0;
    int n_fail  = 0;

    // results gathered by run_xfer
    logic [DW-1:0] got_q[$];
    logic [AW-1:0] addr_log[$];
    int first_valid_rel, done_first_rel, done_cnt, stall_viol, max_outst;
    int busy_cnt, req_cnt, timed_out;

    mega_ram_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
`ifdef MEGA_RAM_READER_LOOP_EN
        .loop     (loop),
`endif
        .base_addr(base_addr),
        .length   (length),
        .ram_req  (ram_req),
        .ram_gnt  (ram_gnt),
        .ram_a    (ram_a),
        .ram_d    (ram_d),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM: data appears the cycle after a granted request
    always @(posedge clk) begin
        if (ram_req && ram_gnt) ram_d <= mem[ram_a];
    end

    function automatic logic pat_ready(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic pat_gnt(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3 != 2);
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Starts a transfer and runs it to completion (plus 3 quiet cycles),
    // recording accepted bytes, issued addresses and handshake statistics.
    // Called at posedge+1. poke_k >= 0 re-asserts start at that cycle.
    task automatic run_xfer(input logic [AW-1:0] b, input logic [LW-1:0] len,
                            input int rmode, input int gmode, input int poke_k,
                            input int budget);
        int outst = 0;
        int tail = 0;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        got_q.delete(); addr_log.delete();
        first_valid_rel = -1; done_first_rel = -1; done_cnt = 0;
        stall_viol = 0; max_outst = 0; busy_cnt = 0; req_cnt = 0; timed_out = 0;
        base_addr = b; length = len; start = 1'b1;
        out_ready = pat_ready(rmode, 0); ram_gnt = pat_gnt(gmode, 0);
        for (int k = 0; k < budget; k++) begin
            if (k > 0) begin
                start = (k == poke_k);
                if (k == poke_k) begin
                    base_addr = b ^ 12'h5A5;
                    length = 12'd3;
                end
                out_ready = pat_ready(rmode, k);
                ram_gnt = pat_gnt(gmode, k);
            end
            @(negedge clk);
            if (k > 0) begin
                if (out_valid && first_valid_rel < 0) first_valid_rel = k - 1;
                if (done) begin
                    done_cnt++;
                    if (done_first_rel < 0) done_first_rel = k - 1;
                end
                if (busy) busy_cnt++;
            end
            if (ram_req) req_cnt++;
            if (prev_stall && out_valid && (out_data !== prev_data)) stall_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (ram_req && ram_gnt) begin addr_log.push_back(ram_a); outst++; end
            if (out_valid && out_ready) begin got_q.push_back(out_data); outst--; end
            if (outst > max_outst) max_outst = outst;
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                tail++;
                if (tail >= 3) break;
            end
        end
        if (done_cnt == 0) timed_out = 1;
        start = 1'b0; out_ready = 1'b1; ram_gnt = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        n_tests++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL reset_ram_req got %b want 0", ram_req); end
        n_tests++; if (ram_a !== 12'h000) begin n_fail++; $display("FAIL reset_ram_a got %h want 000", ram_a); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) mem[16 + i] = 8'hA0 + 8'(i);
        run_xfer(12'h010, 12'd4, 0, 0, -1, 40);
        n_tests++; if (timed_out !== 0) begin n_fail++; $display("FAIL basic_timeout got no done, want done"); end
        n_tests++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", i, got_q[i], 8'hA0 + 8'(i)); end
        end
        n_tests++; if (first_valid_rel !== 2) begin n_fail++; $display("FAIL basic_first_valid got cycle %0d want 2", first_valid_rel); end
        n_tests++; if (done_first_rel !== 6) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 6", done_first_rel); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] want;
        run_xfer(12'hFFE, 12'd4, 0, 0, -1, 40);
        n_tests++; if (addr_log.size() !== 4) begin n_fail++; $display("FAIL wrap_addr_count got %0d want 4", addr_log.size()); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            want = 12'hFFE + 12'(i);
            n_tests++; if (addr_log[i] !== want) begin n_fail++; $display("FAIL wrap_addr%0d got %h want %h", i, addr_log[i], want); end
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            want = 12'hFFE + 12'(i);
            n_tests++; if (got_q[i] !== mem[want]) begin n_fail++; $display("FAIL wrap_byte%0d got %h want %h", i, got_q[i], mem[want]); end
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] b, a;
        b = 12'($urandom);
        run_xfer(b, 12'd8, 1, 1, -1, 100);
        n_tests++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL stall_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            a = b + 12'(i);
            n_tests++; if (got_q[i] !== mem[a]) begin n_fail++; $display("FAIL stall_byte%0d got %h want %h", i, got_q[i], mem[a]); end
        end
        n_tests++; if (max_outst > 2) begin n_fail++; $display("FAIL stall_outstanding got %0d want <=2", max_outst); end
        n_tests++; if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_hold got %0d changes want 0", stall_viol); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_len();
        run_xfer(12'h123, 12'd0, 0, 0, -1, 20);
        n_tests++; if (req_cnt !== 0) begin n_fail++; $display("FAIL zero_req got %0d cycles want 0", req_cnt); end
        n_tests++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL zero_busy got %0d cycles want 0", busy_cnt); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count got %0d want 1", done_cnt); end
        n_tests++; if (done_first_rel !== 0) begin n_fail++; $display("FAIL zero_done_cycle got %0d want 0", done_first_rel); end
        n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL zero_bytes got %0d want 0", got_q.size()); end
    endtask

    task automatic test_start_ignored();
        logic [AW-1:0] b, a;
        b = 12'($urandom);
        run_xfer(b, 12'd6, 2, 2, 3, 100);
        n_tests++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL busy_start_count got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            a = b + 12'(i);
            n_tests++; if (got_q[i] !== mem[a]) begin n_fail++; $display("FAIL busy_start_byte%0d got %h want %h", i, got_q[i], mem[a]); end
        end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_start_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        logic [AW-1:0] b, a;
        int len;
        for (int it = 0; it < 6; it++) begin
            b = 12'($urandom);
            len = $urandom_range(1, 12);
            run_xfer(b, 12'(len), 2, 2, -1, 200);
            n_tests++; if (got_q.size() !== len) begin n_fail++; $display("FAIL rand%0d_count got %0d want %0d", it, got_q.size(), len); end
            for (int i = 0; i < len && i < got_q.size(); i++) begin
                a = b + 12'(i);
                n_tests++; if (got_q[i] !== mem[a]) begin n_fail++; $display("FAIL rand%0d_byte%0d got %h want %h", it, i, got_q[i], mem[a]); end
            end
            for (int i = 0; i < len && i < addr_log.size(); i++) begin
                a = b + 12'(i);
                n_tests++; if (addr_log[i] !== a) begin n_fail++; $display("FAIL rand%0d_addr%0d got %h want %h", it, i, addr_log[i], a); end
            end
            n_tests++; if (max_outst > 2) begin n_fail++; $display("FAIL rand%0d_outstanding got %0d want <=2", it, max_outst); end
            n_tests++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rand%0d_hold got %0d want 0", it, stall_viol); end
            n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_done got %0d want 1", it, done_cnt); end
        end
    endtask

    task automatic test_abort();
        logic [AW-1:0] b, a;
        logic [DW-1:0] acc[$];
        int quiet_bad = 0;
        b = 12'($urandom);
        base_addr = b; length = 12'd10; start = 1'b1; out_ready = 1'b1; ram_gnt = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) acc.push_back(out_data);
            @(posedge clk); #1;
            start = 1'b0;
            if (acc.size() == 3) break;
        end
        n_tests++; if (acc.size() !== 3) begin n_fail++; $display("FAIL abort_reach3 got %0d bytes want 3", acc.size()); end
        for (int i = 0; i < 3 && i < acc.size(); i++) begin
            a = b + 12'(i);
            n_tests++; if (acc[i] !== mem[a]) begin n_fail++; $display("FAIL abort_byte%0d got %h want %h", i, acc[i], mem[a]); end
        end
        // abort together with a fresh start: the start must be dropped
        abort = 1'b1; start = 1'b1; length = 12'd5; out_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; out_ready = 1'b1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_tests++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL abort_req got %b want 0", ram_req); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy || out_valid) quiet_bad++;
        end
        n_tests++; if (quiet_bad !== 0) begin n_fail++; $display("FAIL abort_quiet got %0d active cycles want 0", quiet_bad); end
        @(posedge clk); #1;
        b = 12'($urandom);
        run_xfer(b, 12'd2, 0, 0, -1, 30);
        n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL abort_restart_count got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            a = b + 12'(i);
            n_tests++; if (got_q[i] !== mem[a]) begin n_fail++; $display("FAIL abort_restart_byte%0d got %h want %h", i, got_q[i], mem[a]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] b, a;
        int quiet_bad = 0;
        base_addr = 12'($urandom); length = 12'd10; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2; rst = 1'b0; #1;
        n_tests++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req got %b want 0", ram_req); end
        n_tests++; if (ram_a !== 12'h000) begin n_fail++; $display("FAIL midrst_ram_a got %h want 000", ram_a); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h want 00", out_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        @(negedge clk); @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy || out_valid) quiet_bad++;
        end
        n_tests++; if (quiet_bad !== 0) begin n_fail++; $display("FAIL midrst_quiet got %0d active cycles want 0", quiet_bad); end
        @(posedge clk); #1;
        b = 12'($urandom);
        run_xfer(b, 12'd3, 2, 0, -1, 60);
        n_tests++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL midrst_after_count got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            a = b + 12'(i);
            n_tests++; if (got_q[i] !== mem[a]) begin n_fail++; $display("FAIL midrst_after_byte%0d got %h want %h", i, got_q[i], mem[a]); end
        end
    endtask

`ifdef MEGA_RAM_READER_LOOP_EN
    task automatic test_loop();
        logic [AW-1:0] b, a;
        logic [DW-1:0] acc[$];
        int dones = 0;
        int busy_low = 0;
        int finished = 0;
        b = 12'($urandom);
        loop = 1'b1; base_addr = b; length = 12'd2; start = 1'b1;
        out_ready = 1'b1; ram_gnt = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k > 0 && !busy) busy_low++;
            if (done) dones++;
            if (out_valid && out_ready) acc.push_back(out_data);
            @(posedge clk); #1;
            start = 1'b0;
        end
        loop = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (out_valid && out_ready) acc.push_back(out_data);
            if (!busy && !done && dones > 0) begin finished = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        n_tests++; if (finished !== 1) begin n_fail++; $display("FAIL loop_finish got busy still high, want idle"); end
        n_tests++; if (busy_low !== 0) begin n_fail++; $display("FAIL loop_busy got %0d low cycles want 0", busy_low); end
        n_tests++; if (acc.size() < 4 || acc.size() % 2 != 0) begin n_fail++; $display("FAIL loop_count got %0d want even >=4", acc.size()); end
        n_tests++; if (dones !== acc.size() / 2) begin n_fail++; $display("FAIL loop_done got %0d want %0d", dones, acc.size() / 2); end
        for (int i = 0; i < acc.size(); i++) begin
            a = b + 12'(i % 2);
            n_tests++; if (acc[i] !== mem[a]) begin n_fail++; $display("FAIL loop_byte%0d got %h want %h", i, acc[i], mem[a]); end
        end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0; ram_gnt = 1'b1; out_ready = 1'b1;
`ifdef MEGA_RAM_READER_LOOP_EN
        loop = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_len();
        test_start_ignored();
        test_random();
        test_abort();
        test_reset_mid();
`ifdef MEGA_RAM_READER_LOOP_EN
        test_loop();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
